// File: rtl/iob_pipe_reg_vr_pkg.sv
// Shared defaults and helper types for the iob_pipe_reg_vr elastic pipeline register.
// Imported by the top so default parameters live in one place.
package iob_pipe_reg_vr_pkg;

  localparam int unsigned DefDataW = 21;
  localparam int unsigned DefDepth = 2;
  localparam logic [DefDataW-1:0] DefRstVal = '0;

  // Occupancy counter update selected each cycle.
  typedef enum logic [1:0] {
    LvlHold,
    LvlInc,
    LvlDec,
    LvlClr
  } lvl_op_e;

  // Width needed to count 0..depth inclusive.
  function automatic int unsigned level_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/iob_reg_e.sv
// Enabled data register with asynchronous active-high reset and clock enable.
// One instance holds the payload of a single pipeline stage.
module iob_reg_e #(
  parameter int unsigned       DATA_W  = 21,
  parameter logic [DATA_W-1:0] RST_VAL = '0
) (
  input  logic              clk_i,
  input  logic              arst_i,
  input  logic              cke_i,
  input  logic              en_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o
);

  logic [DATA_W-1:0] data_q, data_d;

  always_comb begin
    data_d = data_q;
    if (cke_i && en_i) begin
      data_d = data_i;
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      data_q <= RST_VAL;
    end else begin
      data_q <= data_d;
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/iob_pipe_reg_vr.sv
// Elastic multi-stage pipeline register with valid/ready handshake, combinational
// back-pressure, synchronous flush, clock enable and a registered occupancy count.
module iob_pipe_reg_vr
  import iob_pipe_reg_vr_pkg::*;
#(
  parameter int unsigned       DATA_W  = DefDataW,
  parameter int unsigned       DEPTH   = DefDepth,
  parameter logic [DATA_W-1:0] RST_VAL = DATA_W'(DefRstVal),
  localparam int unsigned      LEVEL_W = level_width(DEPTH)
) (
  input  logic               clk_i,
  input  logic               cke_i,
  input  logic               arst_i,
  input  logic               flush_i,
  input  logic               valid_i,
  input  logic [DATA_W-1:0]  data_i,
  output logic               ready_o,
  output logic               valid_o,
  output logic [DATA_W-1:0]  data_o,
  input  logic               ready_i,
  output logic [LEVEL_W-1:0] level_o
);

  logic [DEPTH-1:0]   valid_q, valid_d;
  logic [DEPTH-1:0]   load;
  logic [DEPTH-1:0]   adv;
  logic [DEPTH-1:0]   in_valid;
  logic [DEPTH-1:0]   stage_en;
  logic [DATA_W-1:0]  stage_in   [DEPTH];
  logic [DATA_W-1:0]  stage_data [DEPTH];
  logic [LEVEL_W-1:0] level_q, level_d;
  logic               in_xfer;
  logic               out_xfer;
  lvl_op_e            lvl_op;

  // adv[k]: stage k's content moves on; load[k]: stage k may capture a new word.
  // Evaluated from the output end so a bubble anywhere lets upstream words collapse into it.
  always_comb begin
    adv  = '0;
    load = '0;
    adv[DEPTH-1] = ready_i;
    for (int k = DEPTH - 1; k > 0; k--) begin
      load[k]  = !valid_q[k] || adv[k];
      adv[k-1] = load[k];
    end
    load[0] = !valid_q[0] || adv[0];
  end

  always_comb begin
    in_valid    = '0;
    in_valid[0] = valid_i;
    stage_in[0] = data_i;
    for (int k = 1; k < DEPTH; k++) begin
      in_valid[k] = valid_q[k-1];
      stage_in[k] = stage_data[k-1];
    end
  end

  assign ready_o  = cke_i & load[0];
  assign valid_o  = cke_i & valid_q[DEPTH-1];
  assign data_o   = stage_data[DEPTH-1];
  assign in_xfer  = valid_i & ready_o;
  assign out_xfer = valid_o & ready_i;

  // Payload only moves with a valid word, so bubbles never toggle the data flops.
  assign stage_en = {DEPTH{cke_i & ~flush_i}} & load & in_valid;

  always_comb begin
    valid_d = valid_q;
    if (cke_i) begin
      if (flush_i) begin
        valid_d = '0;
      end else begin
        for (int k = 0; k < DEPTH; k++) begin
          if (load[k]) begin
            valid_d[k] = in_valid[k];
          end
        end
      end
    end
  end

  always_comb begin
    lvl_op = LvlHold;
    if (cke_i) begin
      if (flush_i) begin
        lvl_op = LvlClr;
      end else if (in_xfer && !out_xfer) begin
        lvl_op = LvlInc;
      end else if (out_xfer && !in_xfer) begin
        lvl_op = LvlDec;
      end
    end
  end

  always_comb begin
    level_d = level_q;
    unique case (lvl_op)
      LvlHold: level_d = level_q;
      LvlInc:  level_d = level_q + LEVEL_W'(1);
      LvlDec:  level_d = level_q - LEVEL_W'(1);
      LvlClr:  level_d = '0;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      valid_q <= '0;
      level_q <= '0;
    end else begin
      valid_q <= valid_d;
      level_q <= level_d;
    end
  end

  assign level_o = level_q;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    iob_reg_e #(
      .DATA_W  (DATA_W),
      .RST_VAL (RST_VAL)
    ) u_stage_reg (
      .clk_i  (clk_i),
      .arst_i (arst_i),
      .cke_i  (cke_i),
      .en_i   (stage_en[k]),
      .data_i (stage_in[k]),
      .data_o (stage_data[k])
    );
  end

endmodule

// File: tb/tb_iob_pipe_reg_vr.sv
// Directed and randomised self-checking bench for iob_pipe_reg_vr.
// Main instance: DEPTH=3; side instances with DEPTH 1, 2, 4 run a scoreboarded random stream.
module tb_iob_pipe_reg_vr;

  localparam logic [20:0] RstVal = 21'h12345;

  logic        clk;
  logic        cke, arst, flush, vin, rin;
  logic [20:0] din;
  logic        ready_o, valid_o;
  logic [20:0] data_o;
  logic [1:0]  level_o;

  int n_checks = 0;
  int n_fail   = 0;

  logic       rnd_on;
  logic [2:0] r_valid, r_ready;
  logic [7:0] r_data [3];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  iob_pipe_reg_vr #(
    .DATA_W  (21),
    .DEPTH   (3),
    .RST_VAL (RstVal)
  ) u_dut (
    .clk_i   (clk),
    .cke_i   (cke),
    .arst_i  (arst),
    .flush_i (flush),
    .valid_i (vin),
    .data_i  (din),
    .ready_o (ready_o),
    .valid_o (valid_o),
    .data_o  (data_o),
    .ready_i (rin),
    .level_o (level_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_rnd
    localparam int unsigned D  = (g == 0) ? 1 : ((g == 1) ? 2 : 4);
    localparam int unsigned LW = $clog2(D + 1);
    logic          rdy_o, vld_o;
    logic [7:0]    dat_o;
    logic [LW-1:0] lvl;
    logic [7:0]    q [$];

    iob_pipe_reg_vr #(
      .DATA_W  (8),
      .DEPTH   (D),
      .RST_VAL (8'h5A)
    ) u_rnd (
      .clk_i   (clk),
      .cke_i   (1'b1),
      .arst_i  (arst),
      .flush_i (1'b0),
      .valid_i (r_valid[g]),
      .data_i  (r_data[g]),
      .ready_o (rdy_o),
      .valid_o (vld_o),
      .data_o  (dat_o),
      .ready_i (r_ready[g]),
      .level_o (lvl)
    );

    always @(negedge clk) begin
      if (rnd_on) begin
        check($sformatf("rnd_d%0d_level", D), 32'(lvl), 32'(q.size()));
        if (vld_o && r_ready[g]) begin
          if (q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL rnd_d%0d_spurious: got 0x%0h, expected no output word", D, dat_o);
          end else begin
            check($sformatf("rnd_d%0d_data", D), 32'(dat_o), 32'(q.pop_front()));
          end
        end
        if (r_valid[g] && rdy_o) q.push_back(r_data[g]);
      end
    end
  end

  typedef struct packed {
    logic        cke;
    logic        flush;
    logic        vin;
    logic [20:0] din;
    logic        rin;
    logic        e_rdy;
    logic        e_vld;
    logic [20:0] e_dat;
    logic [1:0]  e_lvl;
  } vec_t;

  vec_t vecs [22];
  int   first_v, last_v, nv;

  initial begin
    // Back-pressure, flush and clock-enable sequence; expectations seen before each edge.
    vecs[0]  = '{1'b1, 1'b0, 1'b1, 21'h0A, 1'b0, 1'b1, 1'b0, 21'h10, 2'd0};
    vecs[1]  = '{1'b1, 1'b0, 1'b1, 21'h0B, 1'b0, 1'b1, 1'b0, 21'h10, 2'd1};
    vecs[2]  = '{1'b1, 1'b0, 1'b1, 21'h0C, 1'b0, 1'b1, 1'b0, 21'h10, 2'd2};
    vecs[3]  = '{1'b1, 1'b0, 1'b1, 21'h0D, 1'b0, 1'b0, 1'b1, 21'h0A, 2'd3};
    vecs[4]  = '{1'b1, 1'b0, 1'b1, 21'h0D, 1'b1, 1'b1, 1'b1, 21'h0A, 2'd3};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 21'h00, 1'b0, 1'b0, 1'b1, 21'h0B, 2'd3};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 21'h00, 1'b1, 1'b1, 1'b1, 21'h0B, 2'd3};
    vecs[7]  = '{1'b1, 1'b1, 1'b1, 21'h55, 1'b0, 1'b1, 1'b1, 21'h0C, 2'd2};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 21'h00, 1'b1, 1'b1, 1'b0, 21'h0C, 2'd0};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 21'h00, 1'b1, 1'b1, 1'b0, 21'h0C, 2'd0};
    vecs[10] = '{1'b1, 1'b0, 1'b1, 21'h11, 1'b0, 1'b1, 1'b0, 21'h0C, 2'd0};
    vecs[11] = '{1'b1, 1'b0, 1'b1, 21'h12, 1'b0, 1'b1, 1'b0, 21'h0C, 2'd1};
    vecs[12] = '{1'b0, 1'b1, 1'b1, 21'h99, 1'b1, 1'b0, 1'b0, 21'h0C, 2'd2};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 21'h00, 1'b0, 1'b0, 1'b0, 21'h0C, 2'd2};
    vecs[14] = '{1'b0, 1'b1, 1'b1, 21'h98, 1'b1, 1'b0, 1'b0, 21'h0C, 2'd2};
    vecs[15] = '{1'b0, 1'b0, 1'b1, 21'h97, 1'b0, 1'b0, 1'b0, 21'h0C, 2'd2};
    vecs[16] = '{1'b0, 1'b1, 1'b0, 21'h00, 1'b1, 1'b0, 1'b0, 21'h0C, 2'd2};
    vecs[17] = '{1'b1, 1'b0, 1'b1, 21'h13, 1'b0, 1'b1, 1'b0, 21'h0C, 2'd2};
    vecs[18] = '{1'b1, 1'b0, 1'b0, 21'h00, 1'b1, 1'b1, 1'b1, 21'h11, 2'd3};
    vecs[19] = '{1'b1, 1'b0, 1'b0, 21'h00, 1'b1, 1'b1, 1'b1, 21'h12, 2'd2};
    vecs[20] = '{1'b1, 1'b0, 1'b0, 21'h00, 1'b1, 1'b1, 1'b1, 21'h13, 2'd1};
    vecs[21] = '{1'b1, 1'b0, 1'b0, 21'h00, 1'b0, 1'b1, 1'b0, 21'h13, 2'd0};

    cke = 1'b1; arst = 1'b1; flush = 1'b0; vin = 1'b0; rin = 1'b0; din = '0;
    rnd_on = 1'b0; r_valid = '0; r_ready = '0;
    for (int g = 0; g < 3; g++) r_data[g] = '0;

    // Power-on reset.
    repeat (2) @(posedge clk);
    #1;
    check("por_valid_o", 32'(valid_o), 32'(0));
    check("por_level_o", 32'(level_o), 32'(0));
    check("por_data_o", 32'(data_o), 32'(RstVal));
    arst = 1'b0;
    @(negedge clk);
    check("por_release_ready", 32'(ready_o), 32'(1));

    // Mid-stream asynchronous reset with two words in flight.
    @(posedge clk); #1;
    vin = 1'b1; din = 21'h21;
    @(posedge clk); #1;
    din = 21'h22;
    @(posedge clk); #1;
    vin = 1'b0;
    @(posedge clk); #1;
    check("mid_pre_valid_o", 32'(valid_o), 32'(1));
    check("mid_pre_data_o", 32'(data_o), 32'(21'h21));
    check("mid_pre_level_o", 32'(level_o), 32'(2));
    #2 arst = 1'b1;
    #1;
    check("mid_rst_valid_o", 32'(valid_o), 32'(0));
    check("mid_rst_level_o", 32'(level_o), 32'(0));
    check("mid_rst_data_o", 32'(data_o), 32'(RstVal));
    @(posedge clk); #1;
    arst = 1'b0;
    @(negedge clk);
    check("mid_release_ready", 32'(ready_o), 32'(1));
    @(posedge clk); #1;

    // Streaming 0x01..0x10 with ready_i held high.
    first_v = -1; last_v = -1; nv = 0;
    rin = 1'b1;
    for (int c = 0; c < 24; c++) begin
      vin = (c < 16);
      din = 21'(c + 1);
      @(negedge clk);
      if (c < 16) check("stream_ready", 32'(ready_o), 32'(1));
      if (valid_o) begin
        check("stream_data", 32'(data_o), 32'(nv + 1));
        if (first_v < 0) first_v = c;
        last_v = c;
        nv++;
      end
      @(posedge clk); #1;
    end
    vin = 1'b0; rin = 1'b0;
    check("stream_latency", 32'(first_v), 32'(3));
    check("stream_count", 32'(nv), 32'(16));
    check("stream_contiguous", 32'(last_v - first_v), 32'(15));

    // Table-driven back-pressure / flush / clock-enable sequence.
    for (int i = 0; i < 22; i++) begin
      cke = vecs[i].cke; flush = vecs[i].flush; vin = vecs[i].vin;
      din = vecs[i].din; rin = vecs[i].rin;
      @(negedge clk);
      check($sformatf("vec%0d_ready_o", i), 32'(ready_o), 32'(vecs[i].e_rdy));
      check($sformatf("vec%0d_valid_o", i), 32'(valid_o), 32'(vecs[i].e_vld));
      check($sformatf("vec%0d_data_o", i), 32'(data_o), 32'(vecs[i].e_dat));
      check($sformatf("vec%0d_level_o", i), 32'(level_o), 32'(vecs[i].e_lvl));
      @(posedge clk); #1;
    end
    cke = 1'b1; flush = 1'b0; vin = 1'b0; rin = 1'b0;

    // Random streams on DEPTH 1, 2, 4 instances.
    rnd_on = 1'b1;
    for (int c = 0; c < 400; c++) begin
      r_valid = 3'($urandom);
      r_ready = 3'($urandom);
      for (int g = 0; g < 3; g++) r_data[g] = 8'($urandom);
      @(posedge clk); #1;
    end
    rnd_on = 1'b0;
    r_valid = '0;
    @(posedge clk); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
